// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/update sequencer owning the RISC-V program counter.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned    N            = 64,
  parameter logic [N-1:0]   RESET_VECTOR = '0,
  parameter logic [N-1:0]   TRAP_VECTOR  = 'h100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pc_q,
  output logic [N-1:0] pc_d,
  output logic         pc_load,
  output logic         imem_req,
  input  logic         imem_ack,
  output logic         ir_load,
  input  logic         exec_done,
  input  logic         is_branch,
  input  logic         br_taken,
  input  logic         is_jal,
  input  logic         is_jalr,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] rs1_val,
  input  logic         halt,
  input  logic         stall,
  output logic         trap,
  output logic         halted,
  output logic [N-1:0] instret,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALTED = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e       state_q;
  logic [N-1:0] next_pc_q;
  logic [N-1:0] instret_q;
  logic         halted_q;
  logic [N-1:0] target;
  logic [N-1:0] jalr_sum;

  assign jalr_sum = rs1_val + imm;

  always_comb begin
    if (is_jalr) begin
      target = {jalr_sum[N-1:1], 1'b0};
    end else if (is_jal || (is_branch && br_taken)) begin
      target = pc_q + imm;
    end else begin
      target = pc_q + N'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      next_pc_q <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ack && !stall) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt) begin
              state_q   <= S_HALTED;
              halted_q  <= 1'b1;
              instret_q <= instret_q + N'(1);
            end else begin
              next_pc_q <= target;
`ifdef PC_MISALIGN_TRAP_EN
              state_q   <= target[1] ? S_TRAP : S_UPDATE;
`else
              state_q   <= S_UPDATE;
`endif
            end
          end
        end
        S_UPDATE: begin
          if (!stall) begin
            state_q   <= S_FETCH;
            instret_q <= instret_q + N'(1);
          end
        end
        S_HALTED: state_q <= S_HALTED;
        S_TRAP:   state_q <= S_FETCH;
        default:  state_q <= S_RESET;
      endcase
    end
  end

  // Pulses are decoded from the current state and forced low whenever reset is asserted.
  always_comb begin
    pc_d     = next_pc_q;
    pc_load  = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_RESET: begin
        pc_d    = RESET_VECTOR;
        pc_load = 1'b1;
      end
      S_FETCH: begin
        imem_req = !stall;
        ir_load  = imem_ack && !stall;
      end
      S_UPDATE: pc_load = !stall;
      S_TRAP: begin
        pc_d    = TRAP_VECTOR;
        pc_load = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        trap    = 1'b1;
`endif
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_load  = 1'b0;
      imem_req = 1'b0;
      ir_load  = 1'b0;
      trap     = 1'b0;
    end
  end

  assign halted  = halted_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps plus randomized
// instructions compared against an arithmetic PC/instret reference model.
module tb_pc_sequencer;
  localparam int unsigned N  = 64;
  localparam logic [63:0] RV = 64'h0;
  localparam logic [63:0] TV = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_reg;
  logic [63:0] pc_d;
  logic        pc_load, imem_req, imem_ack, ir_load;
  logic        exec_done, is_branch, br_taken, is_jal, is_jalr, halt, stall;
  logic [63:0] imm, rs1_val;
  logic        trap, halted;
  logic [63:0] instret;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  logic [63:0] m_pc;
  logic [63:0] m_ret;

  always #5 clk = ~clk;

  // Program-counter register the sequencer drives.
  always @(posedge clk) if (pc_load) pc_reg <= pc_d;

  pc_sequencer #(.N(N), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst_n(rst_n), .pc_q(pc_reg), .pc_d(pc_d), .pc_load(pc_load),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .exec_done(exec_done), .is_branch(is_branch), .br_taken(br_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .rs1_val(rs1_val),
    .halt(halt), .stall(stall), .trap(trap), .halted(halted),
    .instret(instret), .state(state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec_noise();
    is_branch = 1'($urandom_range(0, 1));
    br_taken  = 1'($urandom_range(0, 1));
    is_jal    = 1'($urandom_range(0, 1));
    is_jalr   = 1'($urandom_range(0, 1));
    halt      = 1'($urandom_range(0, 1));
    imm       = {$urandom, $urandom};
    rs1_val   = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("rst_state", state, 0);
      chk("rst_pc_load", pc_load, 0);
      chk("rst_instret", instret, 0);
      chk("rst_halted", halted, 0);
      chk("rst_imem_req", imem_req, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_pc_load", pc_load, 1);
    chk("rel_pc_d", pc_d, RV);
    tick();
    m_pc = RV; m_ret = 0;
    #1;
    chk("rel_fetch_state", state, 1);
    chk("rel_imem_req", imem_req, 1);
    chk("rel_instret", instret, 0);
    chk("rel_pc_q", pc_reg, m_pc);
  endtask

  task automatic run_instr(input int fw, input int ew, input int sw,
                           input logic br, input logic tk, input logic jal,
                           input logic jalr, input logic hlt,
                           input logic [63:0] im, input logic [63:0] rs);
    logic [63:0] tgt;
    chk("fetch_state", state, 1);
    chk("fetch_pc", pc_reg, m_pc);
    for (int i = 0; i < fw; i++) begin
      stall    = 1'($urandom_range(0, 1));
      imem_ack = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      exec_done = 1'($urandom_range(0, 1));
      #1;
      chk("fetch_req_wait", imem_req, !stall);
      chk("fetch_irl_wait", ir_load, 0);
      chk("fetch_load_wait", pc_load, 0);
      tick();
    end
    stall = 1'b0; imem_ack = 1'b1; exec_done = 1'b0;
    #1;
    chk("fetch_ir_load", ir_load, 1);
    chk("fetch_req", imem_req, 1);
    tick();
    chk("exec_state", state, 2);
    for (int i = 0; i < ew; i++) begin
      exec_done = 1'b0;
      imem_ack  = 1'($urandom_range(0, 1));
      stall     = 1'($urandom_range(0, 1));
      exec_noise();
      #1;
      chk("exec_wait_load", pc_load, 0);
      chk("exec_wait_irl", ir_load, 0);
      tick();
    end
    imem_ack = 1'b0; stall = 1'b0; exec_done = 1'b1;
    is_branch = br; br_taken = tk; is_jal = jal; is_jalr = jalr; halt = hlt;
    imm = im; rs1_val = rs;
    #1;
    chk("exec_done_load", pc_load, 0);
    tick();
    exec_done = 1'b0;
    exec_noise();
    if (jalr)                 tgt = ((rs + im) / 2) * 2;
    else if (jal || (br && tk)) tgt = m_pc + im;
    else                      tgt = m_pc + 4;
    #1;
    if (hlt) begin
      m_ret = m_ret + 1;
      chk("halt_state", state, 4);
      chk("halt_flag", halted, 1);
      chk("halt_instret", instret, m_ret);
      chk("halt_pc_load", pc_load, 0);
      return;
    end
`ifdef PC_MISALIGN_TRAP_EN
    if (tgt[1]) begin
      chk("trap_state", state, 5);
      chk("trap_pulse", trap, 1);
      chk("trap_pc_load", pc_load, 1);
      chk("trap_pc_d", pc_d, TV);
      tick();
      m_pc = TV;
      #1;
      chk("trap_fetch_state", state, 1);
      chk("trap_instret", instret, m_ret);
      chk("trap_pc_q", pc_reg, m_pc);
      return;
    end
`endif
    chk("upd_state", state, 3);
    for (int i = 0; i < sw; i++) begin
      stall = 1'b1;
      #1;
      chk("upd_stall_load", pc_load, 0);
      chk("upd_stall_trap", trap, 0);
      tick();
      chk("upd_stall_state", state, 3);
    end
    stall = 1'b0;
    #1;
    chk("upd_pc_load", pc_load, 1);
    chk("upd_pc_d", pc_d, tgt);
    chk("upd_trap", trap, 0);
    tick();
    m_pc = tgt;
    m_ret = m_ret + 1;
    #1;
    chk("next_fetch_state", state, 1);
    chk("instret", instret, m_ret);
    chk("pc_q_after_update", pc_reg, m_pc);
  endtask

  initial begin
    int cls;
    logic [63:0] rim, rrs;
    logic jx;
    pc_reg = 64'hDEAD_BEEF_0000_0000;
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    is_branch = 1'b0; br_taken = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; halt = 1'b0;
    imm = '0; rs1_val = '0;
    m_pc = RV; m_ret = 0;

    do_reset(3);

    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 64'h10, 64'h0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("seq_pc", pc_reg, 64'h14);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h40);
    run_instr(0, 0, 0, 1, 1, 0, 0, 0, -64'sd8, 64'h0);
    chk("br_taken_pc", pc_reg, 64'h38);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h40);
    run_instr(0, 0, 0, 1, 0, 0, 0, 0, -64'sd8, 64'h0);
    chk("br_not_taken_pc", pc_reg, 64'h44);
    run_instr(1, 1, 0, 1, 1, 0, 1, 0, 64'h4, 64'h1001);
    chk("jalr_pc", pc_reg, 64'h1004);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h1002);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_pc", pc_reg, TV);
`else
    chk("misalign_pc", pc_reg, 64'h1002);
`endif
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("wrap_pc", pc_reg, 64'h0);
    run_instr(3, 2, 4, 0, 0, 0, 0, 0, 64'h0, 64'h0);

    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 4));
      rim = {$urandom, $urandom} & ~64'h3;
      rrs = {$urandom, $urandom} & ~64'h2;
      jx  = 1'($urandom_range(0, 1));
      case (cls)
        0: run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0, jx, 0, 0, 0, rim, rrs);
        1: run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1, 1, 0, 0, 0, rim, rrs);
        2: run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1, 0, 0, 0, 0, rim, rrs);
        3: run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), jx, jx, 1, 0, 0, rim, rrs);
        default: run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), jx, 1, jx, 1, 0, rim, rrs);
      endcase
    end

    // Reset asserted in EXEC alongside exec_done must abandon the instruction.
    imem_ack = 1'b1; stall = 1'b0;
    #1;
    tick();
    chk("midexec_state", state, 2);
    imem_ack = 1'b0; exec_done = 1'b1; is_jal = 1'b1; is_jalr = 1'b0; halt = 1'b0;
    imm = 64'h40; rst_n = 1'b0;
    #1;
    chk("midexec_pc_load", pc_load, 0);
    exec_done = 1'b0;
    do_reset(2);

    run_instr(1, 1, 1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("post_reset_pc", pc_reg, 64'h4);
    run_instr(0, 1, 0, 0, 0, 1, 0, 1, 64'h80, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      imem_ack = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      stall = 1'b0;
      #1;
      chk("halted_req", imem_req, 0);
      chk("halted_flag", halted, 1);
      chk("halted_state", state, 4);
      chk("halted_pc_load", pc_load, 0);
      chk("halted_instret", instret, m_ret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
